// File: rtl/eth_dump_pkg.sv
// eth_dump_pkg: shared FSM states, ASCII constants and the nibble-to-hex helper
package eth_dump_pkg;
    typedef enum logic [2:0] {IDLE, ARMED, PREAMBLE, CAPTURE, DROP, DUMP} state_t;
    typedef enum logic [2:0] {D_RD, D_HDR, D_BYTE, D_CR, D_LF, D_FIN} dump_t;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_L  = 8'h4C;
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? CH_0 + {4'd0, n} : 8'h37 + {4'd0, n};
    endfunction
endpackage

// File: rtl/eth_frame_dumper_if.sv
// eth_frame_dumper_if: character stream towards the UART
//   tx_data  ASCII character, tx_valid  character present, tx_ready  UART accepts
interface eth_frame_dumper_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    modport master (output tx_data, tx_valid, input tx_ready);
    modport slave  (input tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/mii_rx_sampler.sv
// mii_rx_sampler: brings the MII receive pins into the mainclk domain
//   mainclk, rst            system clock, synchronous active-high reset
//   rx_clk, rx_dv, rxd, rx_er  raw asynchronous PHY pins
//   nib, nib_dv, nib_er     nibble and flags captured at the last rx_clk rising edge
//   nib_stb                 one-cycle pulse when a new nibble has been captured
module mii_rx_sampler (
    input  logic       mainclk,
    input  logic       rst,
    input  logic       rx_clk,
    input  logic       rx_dv,
    input  logic [3:0] rxd,
    input  logic       rx_er,
    output logic [3:0] nib,
    output logic       nib_dv,
    output logic       nib_er,
    output logic       nib_stb
);
    logic [2:0] clk_s;
    logic [1:0] dv_s, er_s;
    logic [3:0] d0, d1;
    logic       rise;
    // clk_s[2] is the extra flop used only to find the rising edge
    assign rise = clk_s[1] & ~clk_s[2];
    always_ff @(posedge mainclk) begin
        if (rst) begin
            clk_s   <= '0;
            dv_s    <= '0;
            er_s    <= '0;
            d0      <= '0;
            d1      <= '0;
            nib     <= '0;
            nib_dv  <= 1'b0;
            nib_er  <= 1'b0;
            nib_stb <= 1'b0;
        end else begin
            clk_s   <= {clk_s[1:0], rx_clk};
            dv_s    <= {dv_s[0], rx_dv};
            er_s    <= {er_s[0], rx_er};
            d0      <= rxd;
            d1      <= d0;
            nib_stb <= rise;
            if (rise) begin
                nib    <= d1;
                nib_dv <= dv_s[1];
                nib_er <= er_s[1];
            end
        end
    end
endmodule

// File: rtl/eth_frame_dumper.sv
// eth_frame_dumper: captures one MII frame on request and dumps it as ASCII lines
//   mainclk, rst        system clock, synchronous active-high reset
//   arm                 capture request, honoured only when idle
//   mii_rx_*            asynchronous PHY receive pins
//   tx                  ASCII character stream (master side)
//   busy                high whenever not idle
//   frame_len           byte count of the last captured frame
//   drop_cnt            saturating count of dropped frames
// Build option: ETH_DUMP_LEN_HEADER_EN prefixes each dump with "Lhhhh" CR LF.
module eth_frame_dumper
    import eth_dump_pkg::*;
#(
    parameter int DEPTH      = 2048,
    parameter int MODE       = 1,
    parameter int LINE_BYTES = 16
) (
    input  logic                     mainclk,
    input  logic                     rst,
    input  logic                     arm,
    input  logic                     mii_rx_clk,
    input  logic                     mii_rx_dv,
    input  logic [3:0]               mii_rxd,
    input  logic                     mii_rxer,
    eth_frame_dumper_if.master       tx,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   frame_len,
    output logic [7:0]               drop_cnt
);
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int LW  = $clog2(LINE_BYTES);
    localparam int CPB = (MODE == 1) ? 2 : 8;
`ifdef ETH_DUMP_LEN_HEADER_EN
    localparam dump_t FIRST = D_HDR;
`else
    localparam dump_t FIRST = D_RD;
`endif

    logic [3:0]    nib;
    logic          nib_dv, nib_er, nib_stb;
    state_t        state, state_n;
    dump_t         sub, sub_n;
    logic          hold, hold_n, half, half_n, valid_n, we, take;
    logic [3:0]    lo, lo_n;
    logic [CW-1:0] cnt, cnt_n, len_n, byte_idx, idx_n;
    logic [7:0]    drop_n, data_n, rdata, byte_ch, hdr_ch;
    logic [2:0]    ci, ci_n;
    logic [LW-1:0] lb, lb_n;
    logic [15:0]   hsh;
    logic [7:0]    mem [DEPTH];

    mii_rx_sampler u_sampler (
        .mainclk (mainclk),
        .rst     (rst),
        .rx_clk  (mii_rx_clk),
        .rx_dv   (mii_rx_dv),
        .rxd     (mii_rxd),
        .rx_er   (mii_rxer),
        .nib     (nib),
        .nib_dv  (nib_dv),
        .nib_er  (nib_er),
        .nib_stb (nib_stb)
    );

    assign busy = (state != IDLE);
    assign take = !tx.tx_valid || tx.tx_ready;
    // header digits come out most significant first as ci runs 1..4
    assign hsh    = 16'(frame_len) << {ci - 3'd1, 2'b00};
    assign hdr_ch = (ci == 3'd0) ? CH_L : hex_char(hsh[15:12]);
    assign byte_ch = (MODE == 1) ? (ci[0] ? hex_char(rdata[3:0]) : hex_char(rdata[7:4]))
                                 : (rdata[3'd7 - ci] ? 8'h31 : CH_0);

    always_comb begin
        state_n = state;
        sub_n   = sub;
        hold_n  = hold;
        half_n  = half;
        lo_n    = lo;
        cnt_n   = cnt;
        len_n   = frame_len;
        drop_n  = drop_cnt;
        idx_n   = byte_idx;
        ci_n    = ci;
        lb_n    = lb;
        data_n  = tx.tx_data;
        valid_n = tx.tx_valid;
        we      = 1'b0;
        case (state)
            IDLE: if (arm) begin
                state_n = ARMED;
                hold_n  = nib_dv;
            end
            // hold: armed in the middle of a frame, let it finish first
            ARMED: if (nib_stb) begin
                if (!nib_dv) hold_n = 1'b0;
                else if (!hold) state_n = PREAMBLE;
            end
            PREAMBLE: if (nib_stb) begin
                if (nib_dv && nib == 4'hD) begin
                    state_n = CAPTURE;
                    cnt_n   = '0;
                    half_n  = 1'b0;
                end else if (!nib_dv || nib != 4'h5) begin
                    state_n = ARMED;
                    hold_n  = nib_dv;
                end
            end
            CAPTURE: if (nib_stb) begin
                if (nib_er || (nib_dv && half && cnt == CW'(DEPTH))) begin
                    state_n = DROP;
                    drop_n  = (drop_cnt == 8'hFF) ? drop_cnt : drop_cnt + 8'd1;
                end else if (!nib_dv) begin
                    state_n = (cnt != '0) ? DUMP : ARMED;
                    len_n   = (cnt != '0) ? cnt : frame_len;
                    idx_n   = '0;
                    ci_n    = '0;
                    lb_n    = '0;
                    sub_n   = FIRST;
                end else if (!half) begin
                    lo_n   = nib;
                    half_n = 1'b1;
                end else begin
                    we     = 1'b1;
                    half_n = 1'b0;
                    cnt_n  = cnt + CW'(1);
                end
            end
            DROP: if (nib_stb && !nib_dv) state_n = ARMED;
            DUMP: begin
                if (take) valid_n = 1'b0;
                case (sub)
                    // one idle cycle lets the buffer read for byte_idx settle
                    D_RD: sub_n = D_BYTE;
                    D_HDR: if (take) begin
                        valid_n = 1'b1;
                        data_n  = hdr_ch;
                        ci_n    = (ci == 3'd4) ? 3'd0 : ci + 3'd1;
                        sub_n   = (ci == 3'd4) ? D_CR : D_HDR;
                    end
                    D_BYTE: if (take) begin
                        valid_n = 1'b1;
                        data_n  = byte_ch;
                        ci_n    = ci + 3'd1;
                        if (ci == 3'(CPB - 1)) begin
                            ci_n  = '0;
                            idx_n = byte_idx + CW'(1);
                            lb_n  = lb + LW'(1);
                            sub_n = (idx_n == frame_len || lb == LW'(LINE_BYTES - 1)) ? D_CR : D_RD;
                        end
                    end
                    D_CR: if (take) begin
                        valid_n = 1'b1;
                        data_n  = CH_CR;
                        sub_n   = D_LF;
                    end
                    D_LF: if (take) begin
                        valid_n = 1'b1;
                        data_n  = CH_LF;
                        lb_n    = '0;
                        sub_n   = (byte_idx == frame_len) ? D_FIN : D_RD;
                    end
                    D_FIN: if (take) state_n = IDLE;
                    default: sub_n = D_RD;
                endcase
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge mainclk) begin
        if (rst) begin
            state       <= IDLE;
            sub         <= D_RD;
            hold        <= 1'b0;
            half        <= 1'b0;
            lo          <= '0;
            cnt         <= '0;
            frame_len   <= '0;
            drop_cnt    <= '0;
            byte_idx    <= '0;
            ci          <= '0;
            lb          <= '0;
            tx.tx_data  <= '0;
            tx.tx_valid <= 1'b0;
        end else begin
            state       <= state_n;
            sub         <= sub_n;
            hold        <= hold_n;
            half        <= half_n;
            lo          <= lo_n;
            cnt         <= cnt_n;
            frame_len   <= len_n;
            drop_cnt    <= drop_n;
            byte_idx    <= idx_n;
            ci          <= ci_n;
            lb          <= lb_n;
            tx.tx_data  <= data_n;
            tx.tx_valid <= valid_n;
        end
    end

    always_ff @(posedge mainclk) begin
        if (we) mem[cnt[AW-1:0]] <= {nib, lo};
        rdata <= mem[byte_idx[AW-1:0]];
    end
endmodule
